// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, round count, 128-bit state type
// and the byte-level GF(2^8) helpers used by the round datapath.
// Byte i of a 128-bit block sits at bits [127-8*i -: 8] (FIPS-197 column-major).
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [127:0] aes_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (b^254, 0 maps to 0) followed
    // by the affine transform; avoids carrying a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // MixColumns on one 32-bit column, top byte is row 0.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_enc_ctrl_if.sv
// Handshake and key-store bus of the AES encryption controller.
// slave: controller side; master: producer/consumer/key-store side.
interface aes_enc_ctrl_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_block;
    logic [3:0] rk_idx;
    aes_state_t rk;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_block;
    logic       busy;

    modport slave (
        input  in_valid, in_block, rk, out_ready,
        output in_ready, rk_idx, out_valid, out_block, busy
    );

    modport master (
        output in_valid, in_block, rk, out_ready,
        input  in_ready, rk_idx, out_valid, out_block, busy
    );

endinterface

// File: rtl/aes_round.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns (bypassed on the
// last round) and AddRoundKey. Purely combinational.
// With AES_SPLIT_ROUND_EN defined the MixColumns/AddRoundKey half works on
// state_in (already substituted and shifted by the previous phase), and
// sub_only selects the SubBytes+ShiftRows half as the result.
module aes_round
    import aes_pkg::*;
(
    input  aes_state_t state_in,
    input  aes_state_t rk,
    input  logic       last_round,
    input  logic       sub_only,
    output aes_state_t round_out
);

    aes_state_t sb;
    aes_state_t sr_out;
    aes_state_t mc_in;
    aes_state_t mc;

    genvar gi;

    // Per byte: S-box substitution, then ShiftRows picks row r from column (c+r)%4.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int SRC = (gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4);
            assign sb[127-8*gi -: 8]     = sbox(state_in[127-8*gi -: 8]);
            assign sr_out[127-8*gi -: 8] = sb[127-8*SRC -: 8];
        end
    endgenerate

`ifdef AES_SPLIT_ROUND_EN
    assign mc_in = state_in;
`else
    assign mc_in = sr_out;
`endif

    // MixColumns applied column by column.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign mc[127-32*gi -: 32] = mix_col(mc_in[127-32*gi -: 32]);
        end
    endgenerate

    assign round_out = sub_only   ? sr_out
                     : last_round ? (mc_in ^ rk)
                     :              (mc ^ rk);

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption controller: IDLE -> ROUND (NR rounds) -> DONE.
// Round keys come from an external key store addressed by rk_idx.
// Optional macro AES_SPLIT_ROUND_EN splits each round over two cycles.
module aes_enc_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic           clk,
    input  logic           rst,
    aes_enc_ctrl_if.slave  bus
);

    logic [1:0] fsm_reg;
    logic [3:0] cnt_reg;
    aes_state_t data_reg;
    aes_state_t round_out;
    logic       last_round;
    logic       sub_only;

`ifdef AES_SPLIT_ROUND_EN
    logic       phase_reg;   // 0: SubBytes+ShiftRows, 1: MixColumns+AddRoundKey
    assign sub_only = ~phase_reg;
`else
    assign sub_only = 1'b0;
`endif

    assign last_round = (cnt_reg == 4'(NR));

    aes_round u_round (
        .state_in   (data_reg),
        .rk         (bus.rk),
        .last_round (last_round),
        .sub_only   (sub_only),
        .round_out  (round_out)
    );

    assign bus.in_ready  = (fsm_reg == ST_IDLE);
    assign bus.busy      = (fsm_reg != ST_IDLE);
    assign bus.out_valid = (fsm_reg == ST_DONE);
    assign bus.out_block = (fsm_reg == ST_DONE) ? data_reg : '0;
    assign bus.rk_idx    = (fsm_reg == ST_ROUND) ? cnt_reg : 4'd0;

    // FSM, round counter and state register; reset drops any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg  <= ST_IDLE;
            cnt_reg  <= 4'd0;
            data_reg <= '0;
`ifdef AES_SPLIT_ROUND_EN
            phase_reg <= 1'b0;
`endif
        end else begin
            case (fsm_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data_reg <= bus.in_block ^ bus.rk;
                        cnt_reg  <= 4'd1;
                        fsm_reg  <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
`ifdef AES_SPLIT_ROUND_EN
                    data_reg  <= round_out;
                    phase_reg <= ~phase_reg;
                    if (phase_reg) begin
                        if (last_round) begin
                            cnt_reg <= 4'd0;
                            fsm_reg <= ST_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
`else
                    data_reg <= round_out;
                    if (last_round) begin
                        cnt_reg <= 4'd0;
                        fsm_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
`endif
                end
                ST_DONE: begin
                    if (bus.out_ready) fsm_reg <= ST_IDLE;
                end
                default: fsm_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_enc_ctrl.md
AES_ENC_CTRL -- requirements
Module: aes_enc_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds (AES-128).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  plaintext offered.
REQ-005 SHALL have port in_ready  output  1  controller can accept a block.
REQ-006 SHALL have port in_block  input  128  plaintext, byte 0 in bits [127:120], FIPS-197 column-major order.
REQ-007 SHALL have port rk_idx  output  4  index of the round key currently required (0..NR).
REQ-008 SHALL have port rk  input  128  round key for rk_idx, supplied combinationally by the external key store.
REQ-009 SHALL have port out_valid  output  1  ciphertext available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-011 SHALL have port out_block  output  128  ciphertext, same byte order as in_block.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-014 IDLE: in_ready=1, rk_idx=0; on in_valid, state register <= in_block XOR rk, round counter <= 1, go to ROUND.
REQ-015 ROUND: rk_idx = round counter; each cycle state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk); counter increments.
REQ-016 When counter = NR, the round SHALL omit MixColumns, and the FSM SHALL go to DONE.
REQ-017 DONE: out_valid=1, out_block=state register; on out_ready, go to IDLE; out_block SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 Latency: accept edge to out_valid high SHALL be exactly NR+1 cycles (11 for NR=10).
REQ-019 in_ready SHALL be 0 in ROUND and DONE; in_valid there SHALL be ignored, with no queuing.
REQ-020 A new block SHALL be accepted no earlier than the cycle after the out_ready handshake, giving a throughput of one block per NR+2 cycles.
REQ-021 Round counter SHALL be 4 bits and SHALL never exceed NR; rk_idx SHALL equal 0 in IDLE and DONE.

Reset
REQ-022 rst asserted at any time, including mid-round, SHALL force IDLE, counter=0, state register=0, out_valid=0, in_ready=1 (after release), busy=0.
REQ-023 No partial ciphertext SHALL appear on out_block after reset; the aborted block SHALL be discarded.

Configuration
REQ-024 Macro AES_SPLIT_ROUND_EN, when defined, SHALL split each round into two cycles (phase A: SubBytes+ShiftRows registered; phase B: MixColumns+AddRoundKey), with a 1-bit phase register and rk_idx held across both phases.
REQ-025 With AES_SPLIT_ROUND_EN defined, latency SHALL be 2*NR+1 cycles; without it, latency SHALL be NR+1 and no phase register SHALL exist.

Structure
REQ-026 Shared package aes_pkg SHALL hold the FSM state encoding, NR_AES128=10, and the 128-bit state type.
REQ-027 One sub-module aes_round SHALL wrap the existing sub_bytes, shift_rows, mix_columns, and add_round_key cores, with a last_round input bypassing mix_columns.
REQ-028 The key schedule SHALL stay outside this block.

Verification
REQ-029 Scenario: FIPS-197 C.1, pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f (TB key model) -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept.
REQ-030 Scenario: same vector, probe state after round-1 ShiftRows -> 6353e08c0960e104cd70b751bacad0e7.
REQ-031 Scenario: out_ready held 0 for 5 cycles in DONE -> out_block stable, in_ready=0, second in_valid ignored.
REQ-032 Scenario: rst pulsed when rk_idx=5 -> IDLE next edge, out_valid=0; a subsequent C.1 block still produces the correct ciphertext.
REQ-033 Scenario: back-to-back blocks with in_valid and out_ready held 1 -> accepts spaced exactly 12 cycles apart, both ciphertexts correct.
REQ-034 Scenario: AES_SPLIT_ROUND_EN defined, C.1 vector -> same ciphertext, out_valid 21 cycles after accept.
